// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, state encodings and helpers for the MIPS multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  // Cycles from acceptance of a DIV/DIVU to its HI/LO write cycle.
  localparam int MDU_DIV_CYCLES = 35;

  localparam logic [1:0] MDU_ST_IDLE = 2'd0;
  localparam logic [1:0] MDU_ST_MUL  = 2'd1;
  localparam logic [1:0] MDU_ST_DIV  = 2'd2;
  localparam logic [1:0] MDU_ST_WR   = 2'd3;

  localparam logic [1:0] DIV_ST_IDLE = 2'd0;
  localparam logic [1:0] DIV_ST_ITER = 2'd1;
  localparam logic [1:0] DIV_ST_FIX  = 2'd2;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic [31:0] mag32(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// 32-step restoring divider on magnitudes: one setup cycle, 32 quotient-bit cycles,
// then a sign-fixup cycle in which done is high and the signed results are valid.
module mul_div_unit_div_iter
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        quo_neg,
  input  logic        rem_neg,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [32:0] rem_shift;
  logic [31:0] trial;

  // quo_q doubles as the dividend shift register; quotient bits enter at the bottom.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    trial     = rem_shift[31:0] - dvs_q;
    state_d   = state_q;
    step_d    = step_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    case (state_q)
      DIV_ST_IDLE: begin
        if (start) begin
          state_d = DIV_ST_ITER;
          step_d  = 5'd0;
          rem_d   = 32'd0;
          quo_d   = dividend;
          dvs_d   = divisor;
          qneg_d  = quo_neg;
          rneg_d  = rem_neg;
        end
      end
      DIV_ST_ITER: begin
        if (rem_shift >= {1'b0, dvs_q}) begin
          rem_d = trial;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) state_d = DIV_ST_FIX;
      end
      default: state_d = DIV_ST_IDLE;
    endcase
    if (abort) state_d = DIV_ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DIV_ST_IDLE;
      step_q  <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign done      = (state_q == DIV_ST_FIX);
  assign quotient  = mag32(qneg_q, quo_q);
  assign remainder = mag32(rneg_q, rem_q);

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO multiply/divide unit: sole writer of HI/LO, stalls issue via busy while
// a MULT/DIV is in flight. All outputs are registered.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi_upgrade,
  output logic [31:0] lo_upgrade,
  output logic        hi_ctr_write,
  output logic        lo_ctr_write
);

  localparam int MUL_PIPE = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        hi_we_q, hi_we_d;
  logic        lo_we_q, lo_we_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        div_start_q, div_start_d;
  hilo_t       pipe_q [MUL_PIPE];
  hilo_t       pipe_d [MUL_PIPE];

  logic        accept;
  logic        op_signed;
  logic [63:0] a_wide, b_wide, product;
  logic        div_done;
  logic [31:0] div_quo, div_rem;

  assign accept    = op_valid && !busy_q && !flush;
  assign op_signed = (op_code == MDU_OP_MULT) || (op_code == MDU_OP_DIV);
  // 33-bit signed operands; the low 64 bits of the product cover both signednesses.
  assign a_wide    = {{32{op_signed & src_a[31]}}, src_a};
  assign b_wide    = {{32{op_signed & src_b[31]}}, src_b};
  assign product   = a_wide * b_wide;

  always_comb begin
    pipe_d[0] = hilo_t'(product);
    for (int i = 1; i < MUL_PIPE; i++) pipe_d[i] = pipe_q[i-1];
  end

  mul_div_unit_div_iter u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .abort     (flush),
    .start     (div_start_q),
    .dividend  (mag32(sgn_q & a_q[31], a_q)),
    .divisor   (mag32(sgn_q & b_q[31], b_q)),
    .quo_neg   (sgn_q & (a_q[31] ^ b_q[31])),
    .rem_neg   (sgn_q & a_q[31]),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    hi_we_d     = 1'b0;
    lo_we_d     = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    div_start_d = 1'b0;
    case (state_q)
      MDU_ST_MUL: begin
        if (cnt_q == 3'd1) begin
          state_d = MDU_ST_WR;
          hi_d    = pipe_q[MUL_PIPE-1].hi;
          lo_d    = pipe_q[MUL_PIPE-1].lo;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      MDU_ST_DIV: begin
        if (div_done) begin
          state_d = MDU_ST_WR;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = div_quo;
            hi_d = div_rem;
          end
        end
      end
      default: begin
        // IDLE and the write cycle both accept; opcodes 6-7 fall through as no-ops.
        state_d = MDU_ST_IDLE;
        if (accept) begin
          case (op_code)
            MDU_OP_MULT, MDU_OP_MULTU: begin
              if (MUL_LAT == 1) begin
                state_d = MDU_ST_WR;
                hi_d    = product[63:32];
                lo_d    = product[31:0];
                hi_we_d = 1'b1;
                lo_we_d = 1'b1;
              end else begin
                state_d = MDU_ST_MUL;
                cnt_d   = 3'(MUL_LAT - 1);
              end
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              state_d     = MDU_ST_DIV;
              a_d         = src_a;
              b_d         = src_b;
              sgn_d       = op_signed;
              div_start_d = 1'b1;
            end
            MDU_OP_MTHI: begin
              state_d = MDU_ST_WR;
              hi_d    = src_a;
              hi_we_d = 1'b1;
            end
            MDU_OP_MTLO: begin
              state_d = MDU_ST_WR;
              lo_d    = src_a;
              lo_we_d = 1'b1;
            end
            default: state_d = MDU_ST_IDLE;
          endcase
        end
      end
    endcase
    if (flush) begin
      state_d     = MDU_ST_IDLE;
      hi_d        = hi_q;
      lo_d        = lo_q;
      hi_we_d     = 1'b0;
      lo_we_d     = 1'b0;
      div_start_d = 1'b0;
    end
    busy_d = (state_d == MDU_ST_MUL) || (state_d == MDU_ST_DIV);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= MDU_ST_IDLE;
      cnt_q       <= 3'd0;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      hi_we_q     <= 1'b0;
      lo_we_q     <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      sgn_q       <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      hi_we_q     <= hi_we_d;
      lo_we_q     <= lo_we_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      div_start_q <= div_start_d;
    end
  end

  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
  end

  assign busy         = busy_q;
  assign hi_upgrade   = hi_q;
  assign lo_upgrade   = lo_q;
  assign hi_ctr_write = hi_we_q;
  assign lo_ctr_write = lo_we_q;

endmodule
